div_issue_ctrl: RTL and testbench

Issue controller that drives a pipelined division unit from the execute stage of the RV32IM core. It accepts DIV/DIVU/REM/REMU requests on a valid/ready interface and launches exactly one start pulse per request. It waits for the unit's done, with a watchdog, and returns the result on a valid/ready writeback interface. It handles pipeline flushes at any point, including draining an in-flight operation, and keeps a completed-operation counter.

---
 rtl/div_issue_ctrl.sv | 136 +++++++++++++
 tb/tb_div_issue_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_issue_ctrl.sv
// Issue controller for a pipelined divider: one start pulse per accepted request,
// done/watchdog wait, flush and drain handling, and a registered writeback response.
module div_issue_ctrl #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [2:0]            req_op_i,
  input  logic [DATA_WIDTH-1:0] req_a_i,
  input  logic [DATA_WIDTH-1:0] req_b_i,
  input  logic [4:0]            req_rd_i,
  output logic                  div_start_o,
  output logic [2:0]            div_op_o,
  output logic [DATA_WIDTH-1:0] div_a_o,
  output logic [DATA_WIDTH-1:0] div_b_o,
  input  logic [DATA_WIDTH-1:0] div_result_i,
  input  logic                  div_done_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_result_o,
  output logic [4:0]            rsp_rd_o,
  output logic                  rsp_err_o,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic [31:0]           ops_count_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StLaunch, StWait, StResp, StDrain} state_e;

  state_e                r_state, w_state_d;
  logic [2:0]            r_op;
  logic [DATA_WIDTH-1:0] r_a, r_b, r_result, w_result_d;
  logic [4:0]            r_rd;
  logic                  r_err, w_err_d;
  logic [CntW-1:0]       r_cnt, w_cnt_d;
  logic [31:0]           r_ops, w_ops_d;
  logic                  w_req_ready, w_accept, w_timeout;

  // Held low during reset so every output reads 0 while rst_ni is asserted.
  assign w_req_ready = rst_ni && !flush_i &&
                       ((r_state == StIdle) || ((r_state == StResp) && rsp_ready_i));
  assign w_accept    = req_valid_i && w_req_ready;
  assign w_timeout   = (r_cnt == CntMax);

  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_result_d = r_result;
    w_err_d    = r_err;
    w_ops_d    = r_ops;
    unique case (r_state)
      StIdle: begin
        if (w_accept) w_state_d = StLaunch;
      end
      StLaunch: begin
        w_cnt_d   = '0;
        w_state_d = flush_i ? StIdle : StWait;
      end
      StWait: begin
        // A flush coinciding with done means the unit is already idle: skip DRAIN.
        if (flush_i) begin
          w_state_d = div_done_i ? StIdle : StDrain;
        end else if (div_done_i) begin
          w_result_d = div_result_i;
          w_err_d    = 1'b0;
          w_state_d  = StResp;
        end else if (w_timeout) begin
          w_result_d = '0;
          w_err_d    = 1'b1;
          w_state_d  = StResp;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      StResp: begin
        if (flush_i) begin
          w_state_d = StIdle;
        end else if (rsp_ready_i) begin
          w_ops_d   = r_ops + 32'd1;
          w_state_d = w_accept ? StLaunch : StIdle;
        end
      end
      StDrain: begin
        if (div_done_i || w_timeout) w_state_d = StIdle;
        else                         w_cnt_d   = r_cnt + 1'b1;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= StIdle;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_rd     <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
      r_ops    <= '0;
    end else begin
      r_state  <= w_state_d;
      r_result <= w_result_d;
      r_err    <= w_err_d;
      r_cnt    <= w_cnt_d;
      r_ops    <= w_ops_d;
      if (w_accept) begin
        r_op <= req_op_i;
        r_a  <= req_a_i;
        r_b  <= req_b_i;
        r_rd <= req_rd_i;
      end
    end
  end

  assign req_ready_o  = w_req_ready;
  assign div_start_o  = (r_state == StLaunch) && !flush_i;
  assign div_op_o     = r_op;
  assign div_a_o      = r_a;
  assign div_b_o      = r_b;
  // Gated by flush so a dropped response never looks like a handoff.
  assign rsp_valid_o  = (r_state == StResp) && !flush_i;
  assign rsp_result_o = r_result;
  assign rsp_rd_o     = r_rd;
  assign rsp_err_o    = r_err;
  assign stall_o      = (r_state == StLaunch) || (r_state == StWait) || (r_state == StDrain);
  assign ops_count_o  = r_ops;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl: a latency-programmable divider model,
// a response scoreboard popped by an independent monitor, and directed checks.
module tb_div_issue_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i, req_ready_o;
  logic [2:0]  req_op_i;
  logic [31:0] req_a_i, req_b_i;
  logic [4:0]  req_rd_i;
  logic        div_start_o;
  logic [2:0]  div_op_o;
  logic [31:0] div_a_o, div_b_o, div_result_i;
  logic        div_done_i;
  logic        rsp_valid_o, rsp_ready_i;
  logic [31:0] rsp_result_o;
  logic [4:0]  rsp_rd_o;
  logic        rsp_err_o, flush_i, stall_o;
  logic [31:0] ops_count_o;

  div_issue_ctrl #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_a_i(req_a_i), .req_b_i(req_b_i), .req_rd_i(req_rd_i),
    .div_start_o(div_start_o), .div_op_o(div_op_o), .div_a_o(div_a_o), .div_b_o(div_b_o),
    .div_result_i(div_result_i), .div_done_i(div_done_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_result_o(rsp_result_o),
    .rsp_rd_o(rsp_rd_o), .rsp_err_o(rsp_err_o), .flush_i(flush_i), .stall_o(stall_o),
    .ops_count_o(ops_count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_vec = 0, n_err = 0;
  int   n_start = 0, n_vcyc = 0, cyc = 0;
  int   lat = 4;
  bit   unit_mute = 1'b0;

  always @(posedge clk_i) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: counts start pulses and valid cycles, pops scoreboard on each handoff.
  always @(negedge clk_i) begin
    if (div_start_o) n_start++;
    if (rsp_valid_o) n_vcyc++;
    if (rsp_valid_o && rsp_ready_i) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_rsp: got rd %0d result %0h, want no response", rsp_rd_o,
                 rsp_result_o);
      end else begin
        mon_e = sb_q.pop_front();
        chk("rsp_result", rsp_result_o, mon_e.res);
        chk("rsp_rd", 32'(rsp_rd_o), 32'(mon_e.rd));
        chk("rsp_err", 32'(rsp_err_o), 32'(mon_e.err));
      end
    end
  end

  // Divider model: samples start at negedge, raises done lat cycles after the start cycle.
  int          u_cd;
  bit          u_start;
  logic [2:0]  u_op;
  logic [31:0] u_a, u_b, u_pend;
  initial begin
    div_done_i   = 1'b0;
    div_result_i = '0;
    u_cd         = 0;
    forever begin
      @(negedge clk_i);
      u_start = div_start_o && !unit_mute;
      u_op    = div_op_o;
      u_a     = div_a_o;
      u_b     = div_b_o;
      @(posedge clk_i);
      #1;
      div_done_i = 1'b0;
      if (u_cd > 0) begin
        u_cd--;
        if (u_cd == 0) begin
          div_done_i   = 1'b1;
          div_result_i = u_pend;
        end
      end
      if (u_start) begin
        case (u_op)
          3'b100:  u_pend = $signed(u_a) / $signed(u_b);
          3'b101:  u_pend = u_a / u_b;
          3'b110:  u_pend = $signed(u_a) % $signed(u_b);
          default: u_pend = u_a % u_b;
        endcase
        if (lat <= 1) begin
          div_done_i   = 1'b1;
          div_result_i = u_pend;
        end else begin
          u_cd = lat - 1;
        end
      end
    end
  end

  // Presents a request in the current cycle; returns at T+1 (+1 time unit) with valid dropped.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output int t);
    req_valid_i = 1'b1;
    req_op_i    = op;
    req_a_i     = a;
    req_b_i     = b;
    req_rd_i    = rd;
    @(negedge clk_i);
    chk("req_ready_on_issue", 32'(req_ready_o), 32'd1);
    t = cyc;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
  endtask

  task automatic wait_rsp(input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk_i);
      if (rsp_valid_o) begin
        at = cyc;
        return;
      end
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  int t, at, s0, v0;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_ni = 1'b0; req_valid_i = 1'b0; req_op_i = '0; req_a_i = '0; req_b_i = '0;
    req_rd_i = '0; rsp_ready_i = 1'b1; flush_i = 1'b0;
    @(negedge clk_i);
    chk("reset_req_ready", 32'(req_ready_o), 32'd0);
    chk("reset_stall", 32'(stall_o), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("reset_div_a", div_a_o, 32'd0);
    chk("reset_ops", ops_count_o, 32'd0);
    step();
    rst_ni = 1'b1;
    step();

    // DIVU 100/7, L=4
    lat = 4;
    sb_q.push_back('{res: 32'd14, rd: 5'd5, err: 1'b0});
    s0 = n_start;
    issue(3'b101, 32'd100, 32'd7, 5'd5, t);
    @(negedge clk_i);
    chk("t1_start", 32'(div_start_o), 32'd1);
    chk("t1_div_op", 32'(div_op_o), 32'h5);
    chk("t1_div_a", div_a_o, 32'd100);
    chk("t1_div_b", div_b_o, 32'd7);
    wait_rsp(20, at);
    chk("t1_rsp_latency", at - t, 32'd6);
    step();
    chk("t1_ops", ops_count_o, 32'd1);
    chk("t1_starts", n_start - s0, 32'd1);

    // Back-to-back REM(-7,2) then DIV(-7,2)
    sb_q.push_back('{res: 32'hFFFF_FFFF, rd: 5'd1, err: 1'b0});
    sb_q.push_back('{res: 32'hFFFF_FFFD, rd: 5'd2, err: 1'b0});
    s0 = n_start;
    issue(3'b110, -32'sd7, 32'd2, 5'd1, t);
    req_valid_i = 1'b1; req_op_i = 3'b100; req_a_i = -32'sd7; req_b_i = 32'd2; req_rd_i = 5'd2;
    at = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (req_ready_o) begin
        at = cyc;
        break;
      end
    end
    chk("t2_accept_in_handoff", 32'(rsp_valid_o), 32'd1);
    chk("t2_accept_cycle", at - t, 32'd6);
    step();
    req_valid_i = 1'b0;
    wait_rsp(20, at);
    step();
    chk("t2_starts", n_start - s0, 32'd2);
    chk("t2_ops", ops_count_o, 32'd3);

    // Backpressure: 5 cycles held in RESP
    rsp_ready_i = 1'b0;
    lat = 3;
    sb_q.push_back('{res: 32'd10, rd: 5'd7, err: 1'b0});
    issue(3'b101, 32'd50, 32'd5, 5'd7, t);
    wait_rsp(20, at);
    s0 = n_start;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("bp_valid", 32'(rsp_valid_o), 32'd1);
      chk("bp_result", rsp_result_o, 32'd10);
      chk("bp_rd", 32'(rsp_rd_o), 32'd7);
      chk("bp_err", 32'(rsp_err_o), 32'd0);
      chk("bp_req_ready", 32'(req_ready_o), 32'd0);
    end
    step();
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    chk("bp_handoff_ready", 32'(req_ready_o), 32'd1);
    step();
    chk("bp_ops", ops_count_o, 32'd4);
    chk("bp_starts", n_start - s0, 32'd0);

    // Flush in LAUNCH
    s0 = n_start;
    issue(3'b101, 32'd9, 32'd3, 5'd3, t);
    flush_i = 1'b1;
    @(negedge clk_i);
    chk("fl_launch_start", 32'(div_start_o), 32'd0);
    step();
    flush_i = 1'b0;
    @(negedge clk_i);
    chk("fl_launch_idle", 32'(stall_o), 32'd0);
    chk("fl_launch_starts", n_start - s0, 32'd0);
    step();

    // Flush in WAIT: drain until done, no response
    lat = 4;
    s0 = n_start;
    v0 = n_vcyc;
    issue(3'b101, 32'd9, 32'd3, 5'd3, t);
    step();
    flush_i = 1'b1;
    @(negedge clk_i);
    chk("fl_wait_stall", 32'(stall_o), 32'd1);
    step();
    flush_i = 1'b0;
    at = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (!stall_o) begin
        at = cyc;
        break;
      end
    end
    chk("fl_drain_exit", at - t, 32'd6);
    chk("fl_drain_starts", n_start - s0, 32'd1);
    chk("fl_drain_no_rsp", n_vcyc - v0, 32'd0);
    step();

    // Flush in RESP: response dropped, not counted
    rsp_ready_i = 1'b0;
    lat = 3;
    issue(3'b101, 32'd8, 32'd2, 5'd4, t);
    wait_rsp(20, at);
    step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    chk("fl_resp_valid", 32'(rsp_valid_o), 32'd0);
    chk("fl_resp_idle", 32'(stall_o), 32'd0);
    chk("fl_resp_ops", ops_count_o, 32'd4);
    step();

    // Flush with a request in IDLE: not accepted
    s0 = n_start;
    flush_i = 1'b1;
    req_valid_i = 1'b1; req_op_i = 3'b101; req_a_i = 32'd1; req_b_i = 32'd1; req_rd_i = 5'd6;
    @(negedge clk_i);
    chk("fl_idle_ready", 32'(req_ready_o), 32'd0);
    step();
    flush_i = 1'b0;
    req_valid_i = 1'b0;
    @(negedge clk_i);
    chk("fl_idle_no_launch", 32'(stall_o), 32'd0);
    chk("fl_idle_starts", n_start - s0, 32'd0);
    step();

    // Watchdog with no done
    unit_mute = 1'b1;
    sb_q.push_back('{res: 32'd0, rd: 5'd9, err: 1'b1});
    issue(3'b100, 32'd1, 32'd1, 5'd9, t);
    wait_rsp(30, at);
    chk("wd_latency", at - t, 32'd10);
    step();
    unit_mute = 1'b0;

    // Done on the timeout cycle wins
    lat = 8;
    sb_q.push_back('{res: 32'd5, rd: 5'd10, err: 1'b0});
    issue(3'b101, 32'd20, 32'd4, 5'd10, t);
    wait_rsp(30, at);
    chk("wd_done_latency", at - t, 32'd10);
    step();
    chk("wd_ops", ops_count_o, 32'd6);

    // Reset asserted in WAIT; done arrives one cycle after release
    lat = 4;
    v0 = n_vcyc;
    issue(3'b101, 32'd30, 32'd3, 5'd11, t);
    step();
    step();
    rst_ni = 1'b0;
    @(negedge clk_i);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_req_ready", 32'(req_ready_o), 32'd0);
    chk("rst_start", 32'(div_start_o), 32'd0);
    chk("rst_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_ops", ops_count_o, 32'd0);
    chk("rst_div_a", div_a_o, 32'd0);
    chk("rst_div_op", 32'(div_op_o), 32'd0);
    chk("rst_rsp_result", rsp_result_o, 32'd0);
    chk("rst_rsp_rd", 32'(rsp_rd_o), 32'd0);
    step();
    rst_ni = 1'b1;
    repeat (5) @(negedge clk_i);
    chk("rst_late_done_idle", 32'(stall_o), 32'd0);
    chk("rst_late_done_no_rsp", n_vcyc - v0, 32'd0);
    chk("rst_late_done_ops", ops_count_o, 32'd0);
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
